// File: rtl/event_serializer.sv
// Serializes filtered DVS events into 4-byte frames (header, x, y, t) on an 8-bit valid/ready bus.
// Header is valid 2 cycles after acceptance; input never stalls, so events are dropped (and counted) when the FIFO is full.

// Circular FIFO with separately tracked occupancy; the caller never pushes when full or pops when empty.
// Write is visible on the next cycle; there is no push-to-pop bypass.
module sync_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are AW bits wide, so DEPTH-1 -> 0 wrap is natural for a power-of-two depth.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
endmodule

module event_serializer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_x,
  input  logic [7:0]    in_y,
  input  logic [7:0]    in_t,
  input  logic          in_p,
  output logic          in_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic [AW:0]   fifo_count,
  output logic [7:0]    drop_count
);
  typedef struct packed {
    logic       p;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] t;
  } evt_t;

  typedef enum logic [2:0] {IDLE, HDR, BX, BY, BT} state_t;

  state_t     state, state_nxt;
  evt_t       in_evt, head, hold, hold_nxt;
  logic       push, pop, fifo_empty;
  logic [7:0] data_nxt;
  logic       sof_nxt;

  assign in_evt     = '{p: in_p, x: in_x, y: in_y, t: in_t};
  assign in_ready   = !rst && (fifo_count != (AW+1)'(DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_empty = (fifo_count == '0);
  assign out_valid  = (state != IDLE);

  sync_fifo #(.W($bits(evt_t)), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (in_evt),
    .pop      (pop),
    .pop_dat  (head),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (in_valid && !in_ready && drop_count != 8'hFF) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    hold_nxt  = hold;
    data_nxt  = 8'h00;
    sof_nxt   = 1'b0;
    unique case (state)
      IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        hold_nxt  = head;
        state_nxt = HDR;
      end
      HDR: if (out_ready) state_nxt = BX;
      BX:  if (out_ready) state_nxt = BY;
      BY:  if (out_ready) state_nxt = BT;
      BT: if (out_ready) begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          hold_nxt  = head;
          state_nxt = HDR;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Output byte is registered, so it is chosen from the state and hold value being entered.
    unique case (state_nxt)
      HDR: begin
        data_nxt = {4'hA, 3'b000, hold_nxt.p};
        sof_nxt  = 1'b1;
      end
      BX:      data_nxt = hold_nxt.x;
      BY:      data_nxt = hold_nxt.y;
      BT:      data_nxt = hold_nxt.t;
      default: data_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold     <= '0;
      out_data <= 8'h00;
      out_sof  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold     <= hold_nxt;
      out_data <= data_nxt;
      out_sof  <= sof_nxt;
    end
  end
endmodule

// File: tb/tb_event_serializer.sv
// Directed bench for event_serializer: latency, back-to-back frames, backpressure, overflow,
// drop saturation and mid-frame reset, all against hand-computed byte sequences.
module tb_event_serializer;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_x, in_y, in_t;
  logic       in_p;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic [2:0] fifo_count;
  logic [7:0] drop_count;

  int errors = 0;
  int checks = 0;

  event_serializer #(.DEPTH(4), .AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_t       (in_t),
    .in_p       (in_p),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .fifo_count (fifo_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] dat, input logic sof);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".sof"},   {31'd0, out_sof},   {31'd0, sof});
    chk({tag, ".data"},  {24'd0, out_data},  {24'd0, dat});
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [7:0] t, input logic p);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    in_t = t;
    in_p = p;
  endtask

  task automatic no_input;
    in_valid = 1'b0;
    in_x = 8'h00;
    in_y = 8'h00;
    in_t = 8'h00;
    in_p = 1'b0;
  endtask

  initial begin
    logic [7:0]  eb;
    logic [31:0] acc;
    int          nacc;
    int          k, b;
    logic [7:0]  prev_drop;
    logic        wrapped;

    // Reset state
    rst = 1'b1;
    out_ready = 1'b1;
    no_input();
    tick();
    tick();
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out_sof", {31'd0, out_sof}, 32'd0);
    chk("rst.out_data", {24'd0, out_data}, 32'd0);
    chk("rst.fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("rst.drop_count", {24'd0, drop_count}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

    // Single event: header valid two cycles after acceptance
    send(8'h12, 8'h34, 8'h56, 1'b1);
    tick();
    no_input();
    chk("single.c1.count", {29'd0, fifo_count}, 32'd1);
    chk("single.c1.valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk_byte("single.b0", 8'hA1, 1'b1);
    tick();
    chk_byte("single.b1", 8'h12, 1'b0);
    tick();
    chk_byte("single.b2", 8'h34, 1'b0);
    tick();
    chk_byte("single.b3", 8'h56, 1'b0);
    tick();
    chk("single.c6.valid", {31'd0, out_valid}, 32'd0);
    chk("single.c6.data", {24'd0, out_data}, 32'd0);
    chk("single.c6.count", {29'd0, fifo_count}, 32'd0);

    // Back-to-back: events c=0..2 with x=c*16+1, y=+2, t=+3, p=c[0]
    for (int c = 0; c <= 14; c++) begin
      if (c < 3) send(8'(16*c + 1), 8'(16*c + 2), 8'(16*c + 3), c[0]);
      else no_input();
      if (c >= 2 && c < 14) begin
        k = (c - 2) / 4;
        b = (c - 2) % 4;
        eb = (b == 0) ? (8'hA0 | 8'(k % 2)) : 8'(16*k + b);
        chk_byte($sformatf("b2b.c%0d", c), eb, b == 0);
      end
      if (c == 14) begin
        chk("b2b.end.valid", {31'd0, out_valid}, 32'd0);
        chk("b2b.drop", {24'd0, drop_count}, 32'd0);
      end
      tick();
    end

    // Backpressure: out_ready 1,0,0 repeating from the header cycle
    acc = 32'd0;
    nacc = 0;
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) send(8'h9A, 8'hBC, 8'hDE, 1'b0);
      else no_input();
      out_ready = (c < 2) ? 1'b1 : ((c - 2) % 3 == 0);
      if (c == 2) chk_byte("bp.c2", 8'hA0, 1'b1);
      else if (c >= 3 && c <= 5) chk_byte($sformatf("bp.c%0d", c), 8'h9A, 1'b0);
      else if (c >= 6 && c <= 8) chk_byte($sformatf("bp.c%0d", c), 8'hBC, 1'b0);
      else if (c >= 9 && c <= 11) chk_byte($sformatf("bp.c%0d", c), 8'hDE, 1'b0);
      else if (c == 12) chk("bp.end.valid", {31'd0, out_valid}, 32'd0);
      if (out_valid && out_ready) begin
        acc = {acc[23:0], out_data};
        nacc++;
      end
      tick();
    end
    chk("bp.accepted_bytes", acc, 32'hA09ABCDE);
    chk("bp.accepted_count", nacc, 32'd4);
    out_ready = 1'b1;

    // Overflow: events k=1..6 with x=40+k, y=50+k, t=60+k, p=k[0]; consumer stalled until cycle 6
    for (int c = 0; c <= 26; c++) begin
      k = c + 1;
      if (c <= 5) send(8'(8'h40 + k), 8'(8'h50 + k), 8'(8'h60 + k), k[0]);
      else no_input();
      out_ready = (c >= 6);
      if (c == 4) chk("ovf.c4.in_ready", {31'd0, in_ready}, 32'd1);
      if (c == 5) begin
        chk("ovf.c5.in_ready", {31'd0, in_ready}, 32'd0);
        chk("ovf.c5.count", {29'd0, fifo_count}, 32'd4);
      end
      if (c == 6) begin
        chk("ovf.c6.drop", {24'd0, drop_count}, 32'd1);
        chk("ovf.c6.count", {29'd0, fifo_count}, 32'd4);
      end
      if (c >= 2 && c <= 5) chk_byte($sformatf("ovf.stall.c%0d", c), 8'hA1, 1'b1);
      if (c >= 6 && c <= 25) begin
        k = (c - 6) / 4 + 1;
        b = (c - 6) % 4;
        case (b)
          0: eb = 8'hA0 | 8'(k % 2);
          1: eb = 8'(8'h40 + k);
          2: eb = 8'(8'h50 + k);
          default: eb = 8'(8'h60 + k);
        endcase
        chk_byte($sformatf("ovf.c%0d", c), eb, b == 0);
      end
      if (c == 26) begin
        chk("ovf.end.valid", {31'd0, out_valid}, 32'd0);
        chk("ovf.end.count", {29'd0, fifo_count}, 32'd0);
      end
      tick();
    end

    // Saturation: 5 events absorbed (4 FIFO + hold), the rest dropped, count pinned at 255
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    prev_drop = 8'h00;
    wrapped = 1'b0;
    for (int c = 0; c <= 300; c++) begin
      send(8'h77, 8'h88, 8'h99, 1'b1);
      if (drop_count < prev_drop) wrapped = 1'b1;
      prev_drop = drop_count;
      if (c == 100) chk("sat.c100", {24'd0, drop_count}, 32'd95);
      if (c == 259) chk("sat.c259", {24'd0, drop_count}, 32'd254);
      if (c == 260) chk("sat.c260", {24'd0, drop_count}, 32'd255);
      if (c == 300) chk("sat.c300", {24'd0, drop_count}, 32'd255);
      tick();
    end
    chk("sat.no_wrap", {31'd0, wrapped}, 32'd0);
    no_input();

    // Reset during BY with two events queued, then a clean frame
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    send(8'h71, 8'h72, 8'h73, 1'b1);
    tick();
    send(8'h81, 8'h82, 8'h83, 1'b0);
    tick();
    send(8'h91, 8'h92, 8'h93, 1'b1);
    tick();
    no_input();
    tick();
    chk_byte("mrst.by", 8'h72, 1'b0);
    chk("mrst.by.count", {29'd0, fifo_count}, 32'd2);
    rst = 1'b1;
    tick();
    chk("mrst.valid", {31'd0, out_valid}, 32'd0);
    chk("mrst.count", {29'd0, fifo_count}, 32'd0);
    chk("mrst.drop", {24'd0, drop_count}, 32'd0);
    chk("mrst.data", {24'd0, out_data}, 32'd0);
    rst = 1'b0;
    tick();
    send(8'hE1, 8'hE2, 8'hE3, 1'b0);
    tick();
    no_input();
    chk("mrst.new.c1.valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk_byte("mrst.new.b0", 8'hA0, 1'b1);
    tick();
    chk_byte("mrst.new.b1", 8'hE1, 1'b0);
    tick();
    chk_byte("mrst.new.b2", 8'hE2, 1'b0);
    tick();
    chk_byte("mrst.new.b3", 8'hE3, 1'b0);
    tick();
    chk("mrst.new.end", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
